// File: rtl/tow_input_conditioner.sv
// tow_input_conditioner: synchronises and debounces two raw player keys and
// turns each debounced press into a single enable-gated one-cycle pulse.

module tow_input_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    input  logic enable,
    output logic button,
    output logic held
);
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam bit BYPASS = DEBOUNCE_CYCLES == 1;
    state_t state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;
    logic s1, s2, nheld, npulse;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            state <= RELEASED;
            cnt <= '0;
            held <= 1'b0;
            button <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            state <= nstate;
            cnt <= ncnt;
            held <= nheld;
            button <= npulse;
        end
    end
    // A pulse is only ever produced on the edge that enters HELD from the press side.
    always_comb begin
        nstate = state;
        ncnt = cnt;
        nheld = held;
        npulse = 1'b0;
        case (state)
            RELEASED: begin
                ncnt = '0;
                if (s2) begin
                    nstate = BYPASS ? HELD : PRESS_WAIT;
                    ncnt = BYPASS ? '0 : ONE;
                    nheld = BYPASS;
                    npulse = BYPASS && enable;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    nstate = RELEASED;
                    ncnt = '0;
                end else if (cnt == LAST) begin
                    nstate = HELD;
                    ncnt = '0;
                    nheld = 1'b1;
                    npulse = enable;
                end else begin
                    ncnt = cnt + ONE;
                end
            end
            HELD: begin
                if (!s2) begin
                    nstate = BYPASS ? RELEASED : RELEASE_WAIT;
                    ncnt = BYPASS ? '0 : ONE;
                    nheld = !BYPASS;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    nstate = HELD;
                    ncnt = '0;
                end else if (cnt == LAST) begin
                    nstate = RELEASED;
                    ncnt = '0;
                    nheld = 1'b0;
                end else begin
                    ncnt = cnt + ONE;
                end
            end
            default: begin
                nstate = RELEASED;
                ncnt = '0;
                nheld = 1'b0;
            end
        endcase
    end
endmodule

module tow_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic KeyLeft,
    input  logic KeyRight,
    input  logic enable,
    output logic LeftButton,
    output logic RightButton,
    output logic LeftHeld,
    output logic RightHeld
);
    tow_input_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) left (
        .clock(clock), .reset(reset), .key(KeyLeft), .enable(enable),
        .button(LeftButton), .held(LeftHeld)
    );
    tow_input_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) right (
        .clock(clock), .reset(reset), .key(KeyRight), .enable(enable),
        .button(RightButton), .held(RightHeld)
    );
endmodule

// File: doc/tow_input_conditioner.md
Name: tow_input_conditioner

Overview:
- Player-input front end for the tug-of-war game; sits directly upstream of the playfield light cells.
- Takes two raw, asynchronous key levels and synchronises and debounces each one.
- Emits exactly one single-cycle press pulse per physical press, on the LeftButton/RightButton nets that every playfield light consumes.
- Also exports debounced held levels and gates pulses with a game-enable input, so no moves register while the game is halted.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new key level must persist before it is accepted. Legal range 1 to 2^CNT_W-1.
- CNT_W, 8: width of each per-channel debounce counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- KeyLeft  in  1  raw left-player key, active-high, asynchronous to clock.
- KeyRight  in  1  raw right-player key, active-high, asynchronous to clock.
- enable  in  1  game-active; when 0, press pulses are suppressed.
- LeftButton  out  1  one-cycle press pulse, left player.
- RightButton  out  1  one-cycle press pulse, right player.
- LeftHeld  out  1  debounced left key level.
- RightHeld  out  1  debounced right key level.

Behaviour:
- Reset: asynchronous, active-high. While asserted, all outputs are 0, sync flops are 0, counters are 0, and both channel FSMs are in RELEASED.
- Channels: two identical, fully independent channel instances. No shared state between them.
- Per-channel datapath: 2-flop synchroniser produces s2; a stable-level register is exported as *Held; a CNT_W-bit counter; a 4-state FSM with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
- FSM transitions, evaluated on each rising edge:
  - RELEASED: s2=1 goes to PRESS_WAIT with cnt=1. s2=0 stays, cnt=0.
  - PRESS_WAIT: s2=0 goes back to RELEASED with cnt=0 (glitch rejected). s2=1 with cnt==DEBOUNCE_CYCLES-1 goes to HELD, sets Held=1, clears cnt. Otherwise cnt increments.
  - HELD: s2=0 goes to RELEASE_WAIT with cnt=1. s2=1 stays.
  - RELEASE_WAIT: s2=1 goes back to HELD with cnt=0. s2=0 with cnt==DEBOUNCE_CYCLES-1 goes to RELEASED, sets Held=0, clears cnt. Otherwise cnt increments.
- DEBOUNCE_CYCLES=1: PRESS_WAIT and RELEASE_WAIT are bypassed. The first s2 change flips Held on that same edge.
- Pulse generation:
  - *Button is registered and is 1 for exactly the one cycle following the edge on which the FSM enters HELD from PRESS_WAIT (or from RELEASED when DEBOUNCE_CYCLES=1), provided enable=1 at that edge.
  - In all other cycles *Button is 0.
- Latency: raw key set up before edge 1 gives s2=1 after edge 2, and Held/Button rise after edge 1+DEBOUNCE_CYCLES+1. With the default of 4, that is after edge 6.
- No repeat: holding the key indefinitely produces exactly one pulse. A new pulse requires a full debounced release (return to RELEASED) followed by a new debounced press.
- enable:
  - Gates only the pulses, never the FSM or the Held outputs.
  - A press that completes while enable=0 is consumed: no pulse fires later when enable rises.
- Simultaneous presses: both pulses may assert in the same cycle. The block performs no arbitration; downstream logic treats both-pressed as no move.
- Reset mid-operation: any in-progress count is discarded. A key still held when reset deasserts is treated as a fresh press, and pulses after DEBOUNCE_CYCLES+2 edges if enable=1.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible within the legal parameter range.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
1. Reset, enable=1, KeyLeft 0→1 held for 20 cycles -> LeftButton high for exactly one cycle (after edge 6 from the change). LeftHeld=1 from then on. RightButton and RightHeld stay 0.
2. KeyRight pulsed high for 3 cycles, then low -> no RightButton pulse, RightHeld stays 0. Repeat with 4 cycles -> exactly one pulse.
3. KeyLeft held, then dropped low for 2 cycles and raised again -> LeftHeld stays 1 and no second pulse. Drop for 6 cycles and raise again -> LeftHeld falls, then a second single pulse.
4. KeyLeft and KeyRight rise on the same cycle -> LeftButton and RightButton both high in the same single cycle.
5. enable=0, press KeyRight until RightHeld=1, then set enable=1 while still held -> no RightButton pulse ever. Release, then press again -> one pulse.
6. KeyLeft held high, reset asserted asynchronously mid-debounce (between clock edges) -> outputs 0 immediately. Reset released with key still high -> one LeftButton pulse 6 edges later. Rerun with DEBOUNCE_CYCLES=1 -> pulse after edge 3.
